fault_recovery_ctrl: RTL and testbench
======================================

Name: fault_recovery_ctrl

Overview:
- Supervisory sequencer that sits above fault_fsm and owns the power-stage enable.
- Starts and stops the power stage on host command.
- Auto-clears warnings once the raw conditions have been stable-clear for a set time.
- After a shutdown: cuts power, waits a fault-free cooldown, re-arms fault_fsm through its reset, and retries. Locks out after MAX_RETRY trips until the host acknowledges.

Parameters:
- CNT_W, 16: width of the internal timer.
- COOLDOWN_CYCLES, 100: consecutive fault-free cycles required before re-arm.
- STABLE_CYCLES, 16: consecutive fault-free cycles in warn before a clear_warning pulse.
- MAX_RETRY, 3: trips counted before LOCKOUT (range 1..7).
- HEALTHY_CYCLES, 1000: continuous RUN cycles with warn=0 that reset retry_cnt to 0.
- REARM_CYCLES, 2: cycles fsm_rst_n is held low during re-arm.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  host request to enable power (level, sampled)
- stop  in  1  host request to disable power (level, sampled)
- lockout_clear  in  1  host acknowledge of lockout (single-cycle pulse)
- fsm_state  in  2  fault_fsm state: 0 NORMAL, 1 WARN, 2 FAULT, 3 SHUTDOWN
- warn  in  1  fault_fsm warn
- shutdown  in  1  fault_fsm shutdown
- active_fault_id  in  3  fault_fsm active fault id
- raw_fault_any  in  1  OR of unmasked raw ov/uv/ot/uc
- pwr_en  out  1  power-stage enable (registered)
- clear_warning  out  1  one-cycle pulse to fault_fsm
- fsm_rst_n  out  1  registered active-low reset to fault_fsm
- lockout  out  1  high in LOCKOUT
- retry_cnt  out  3  trips since last healthy period or lockout clear
- last_fault_id  out  3  active_fault_id captured at the most recent trip
- ctrl_state  out  3  0 OFF, 1 RUN, 2 TRIP, 3 COOLDOWN, 4 REARM, 5 LOCKOUT

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: ctrl_state=OFF, pwr_en=0, clear_warning=0, fsm_rst_n=1, lockout=0, retry_cnt=0, last_fault_id=0, timer=0.
- All outputs are registered. A state change and its outputs appear on the same edge, one cycle after the input is sampled.
- OFF: pwr_en=0. If start=1, stop=0, raw_fault_any=0 and shutdown=0, go to RUN.
- RUN: pwr_en=1. Transitions are checked in this priority order:
  - shutdown=1: go to TRIP. This wins over a simultaneous stop.
  - stop=1: go to OFF.
- RUN, warn auto-clear:
  - While warn=1 and raw_fault_any=0, the timer counts up.
  - When the timer reaches STABLE_CYCLES, clear_warning pulses for 1 cycle and the timer resets.
  - raw_fault_any=1 or warn=0 resets the timer.
- RUN, healthy count: a separate counter counts cycles with warn=0. At HEALTHY_CYCLES, retry_cnt goes to 0. Any warn=1 resets this counter.
- TRIP: exactly 1 cycle. pwr_en=0.
  - last_fault_id captures active_fault_id as sampled in the RUN cycle that saw shutdown.
  - retry_cnt increments, saturating at 7.
  - If the new retry_cnt >= MAX_RETRY, go to LOCKOUT; otherwise go to COOLDOWN.
- COOLDOWN: pwr_en=0.
  - The timer counts cycles with raw_fault_any=0. raw_fault_any=1 resets it to 0.
  - When the timer reaches COOLDOWN_CYCLES, go to REARM.
  - stop=1 goes to OFF; retry_cnt is kept.
- REARM: fsm_rst_n=0 for REARM_CYCLES cycles, then fsm_rst_n=1 and go to RUN with pwr_en=1.
  - If raw_fault_any=1 during REARM, return to COOLDOWN with timer=0.
  - stop=1 goes to OFF with fsm_rst_n=1.
- LOCKOUT: pwr_en=0, lockout=1. start and stop are ignored.
  - lockout_clear=1 with raw_fault_any=0: retry_cnt=0, go to REARM. REARM exits to OFF, not RUN.
  - lockout_clear with raw_fault_any=1 is ignored.
- Other states: clear_warning is never asserted outside RUN.
- Timer: saturates at its maximum and never wraps. Parameters must satisfy STABLE_CYCLES, COOLDOWN_CYCLES, HEALTHY_CYCLES < 2^CNT_W.
- Reset mid-operation (any state): immediate return to reset values. pwr_en drops asynchronously; fsm_rst_n returns to 1.
- Undefined ctrl_state encodings (6, 7) go to OFF on the next edge.

Test Plan:
Bench parameters: COOLDOWN_CYCLES=10, STABLE_CYCLES=4, MAX_RETRY=2, HEALTHY_CYCLES=50, REARM_CYCLES=2.
- start=1 with raw_fault_any=0 -> ctrl_state=1 and pwr_en=1 one cycle later. Then stop=1 -> ctrl_state=0 and pwr_en=0 next cycle.
- RUN with warn=1 and raw_fault_any=0 for 4 cycles -> exactly one clear_warning pulse. Repeat with raw_fault_any toggling every 3 cycles -> no pulse.
- RUN, shutdown=1 with active_fault_id=3 -> TRIP for 1 cycle, pwr_en=0, retry_cnt=1, last_fault_id=3. Hold raw_fault_any=1 for 5 cycles -> still COOLDOWN. Then 10 clear cycles -> REARM with fsm_rst_n low for 2 cycles -> RUN, pwr_en=1.
- Two trips without a healthy interval -> retry_cnt=2, LOCKOUT, lockout=1. start is ignored. lockout_clear while raw_fault_any=1 is ignored. lockout_clear while clear -> REARM -> OFF with retry_cnt=0.
- One trip, then 50 RUN cycles with warn=0 -> retry_cnt returns to 0. Shutdown and stop in the same cycle -> TRIP, not OFF.
- rst_n asserted low mid-COOLDOWN and mid-REARM -> all outputs return to reset values immediately; fsm_rst_n=1.

Source files
------------

// File: rtl/fault_recovery_ctrl.sv
// Supervisory sequencer above fault_fsm: owns the power-stage enable,
// auto-clears stale warnings, and runs the trip / cooldown / re-arm / retry
// loop with a lockout after too many trips.
module fault_recovery_ctrl #(
  parameter int CNT_W           = 16,
  parameter int COOLDOWN_CYCLES = 100,
  parameter int STABLE_CYCLES   = 16,
  parameter int MAX_RETRY       = 3,
  parameter int HEALTHY_CYCLES  = 1000,
  parameter int REARM_CYCLES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       lockout_clear,
  input  logic [1:0] fsm_state,
  input  logic       warn,
  input  logic       shutdown,
  input  logic [2:0] active_fault_id,
  input  logic       raw_fault_any,
  output logic       pwr_en,
  output logic       clear_warning,
  output logic       fsm_rst_n,
  output logic       lockout,
  output logic [2:0] retry_cnt,
  output logic [2:0] last_fault_id,
  output logic [2:0] ctrl_state
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_RUN   = 3'd1,
    S_TRIP  = 3'd2,
    S_COOL  = 3'd3,
    S_REARM = 3'd4,
    S_LOCK  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] STABLE_T  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] COOL_T    = CNT_W'(COOLDOWN_CYCLES);
  localparam logic [CNT_W-1:0] HEALTHY_T = CNT_W'(HEALTHY_CYCLES);
  localparam logic [CNT_W-1:0] REARM_T   = CNT_W'(REARM_CYCLES);
  localparam logic [2:0]       MAX_T     = 3'(MAX_RETRY);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d, timer_inc;
  logic [CNT_W-1:0] hlth_q, hlth_d;
  logic             to_off_q, to_off_d;   // re-arm came from lockout clear: exit to OFF
  logic             pwr_d, cw_d, frn_d, lock_d;
  logic [2:0]       retry_d, lfid_d;

  // fault_fsm state is informational only; the controller acts on warn/shutdown.
  logic unused_fsm_state;
  assign unused_fsm_state = ^fsm_state;

  assign ctrl_state = state_q;

  // Saturating increment so the timer never wraps.
  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + CNT_W'(1);

  // State, timers and all outputs are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_OFF;
      timer_q       <= '0;
      hlth_q        <= '0;
      to_off_q      <= 1'b0;
      pwr_en        <= 1'b0;
      clear_warning <= 1'b0;
      fsm_rst_n     <= 1'b1;
      lockout       <= 1'b0;
      retry_cnt     <= 3'd0;
      last_fault_id <= 3'd0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      hlth_q        <= hlth_d;
      to_off_q      <= to_off_d;
      pwr_en        <= pwr_d;
      clear_warning <= cw_d;
      fsm_rst_n     <= frn_d;
      lockout       <= lock_d;
      retry_cnt     <= retry_d;
      last_fault_id <= lfid_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    timer_d  = '0;
    hlth_d   = '0;
    to_off_d = to_off_q;
    pwr_d    = 1'b0;
    cw_d     = 1'b0;
    frn_d    = 1'b1;
    lock_d   = 1'b0;
    retry_d  = retry_cnt;
    lfid_d   = last_fault_id;
    case (state_q)
      S_OFF: begin
        to_off_d = 1'b0;
        if (start && !stop && !raw_fault_any && !shutdown) begin
          state_d = S_RUN;
          pwr_d   = 1'b1;
        end
      end
      S_RUN: begin
        if (shutdown) begin
          // Shutdown outranks a simultaneous stop.
          state_d = S_TRIP;
          lfid_d  = active_fault_id;
          retry_d = (retry_cnt == 3'd7) ? 3'd7 : retry_cnt + 3'd1;
        end else if (stop) begin
          state_d = S_OFF;
        end else begin
          pwr_d = 1'b1;
          // Warning auto-clear once raw conditions have stayed quiet.
          if (warn && !raw_fault_any) begin
            if (timer_inc == STABLE_T) cw_d = 1'b1;
            else                       timer_d = timer_inc;
          end
          // A long warn-free run forgives earlier trips.
          if (!warn) begin
            hlth_d = (hlth_q == HEALTHY_T) ? hlth_q : hlth_q + CNT_W'(1);
            if (hlth_d == HEALTHY_T) retry_d = 3'd0;
          end
        end
      end
      S_TRIP: begin
        if (retry_cnt >= MAX_T) begin
          state_d = S_LOCK;
          lock_d  = 1'b1;
        end else begin
          state_d = S_COOL;
        end
      end
      S_COOL: begin
        if (stop) begin
          state_d  = S_OFF;
          to_off_d = 1'b0;
        end else if (!raw_fault_any) begin
          if (timer_inc == COOL_T) begin
            state_d = S_REARM;
            frn_d   = 1'b0;
          end else begin
            timer_d = timer_inc;
          end
        end
      end
      S_REARM: begin
        if (stop) begin
          state_d  = S_OFF;
          to_off_d = 1'b0;
        end else if (raw_fault_any) begin
          state_d = S_COOL;
        end else if (timer_inc == REARM_T) begin
          to_off_d = 1'b0;
          if (to_off_q) begin
            state_d = S_OFF;
          end else begin
            state_d = S_RUN;
            pwr_d   = 1'b1;
          end
        end else begin
          timer_d = timer_inc;
          frn_d   = 1'b0;
        end
      end
      S_LOCK: begin
        lock_d = 1'b1;
        if (lockout_clear && !raw_fault_any) begin
          state_d  = S_REARM;
          lock_d   = 1'b0;
          retry_d  = 3'd0;
          frn_d    = 1'b0;
          to_off_d = 1'b1;
        end
      end
      default: begin
        state_d  = S_OFF;
        to_off_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fault_recovery_ctrl.sv
// Bench for fault_recovery_ctrl: directed vector table, asynchronous reset
// sequences, then random stimulus against a countdown-style reference model.
module tb_fault_recovery_ctrl;
  localparam int COOL = 10, STAB = 4, MAXR = 2, HLTH = 50, REARM = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 0, stop = 0, lockout_clear = 0, warn = 0, shutdown = 0, raw_fault_any = 0;
  logic [1:0] fsm_state = 2'd0;
  logic [2:0] active_fault_id = 3'd0;
  logic pwr_en, clear_warning, fsm_rst_n, lockout;
  logic [2:0] retry_cnt, last_fault_id, ctrl_state;

  fault_recovery_ctrl #(
    .CNT_W(16), .COOLDOWN_CYCLES(COOL), .STABLE_CYCLES(STAB), .MAX_RETRY(MAXR),
    .HEALTHY_CYCLES(HLTH), .REARM_CYCLES(REARM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .lockout_clear(lockout_clear),
    .fsm_state(fsm_state), .warn(warn), .shutdown(shutdown), .active_fault_id(active_fault_id),
    .raw_fault_any(raw_fault_any), .pwr_en(pwr_en), .clear_warning(clear_warning),
    .fsm_rst_n(fsm_rst_n), .lockout(lockout), .retry_cnt(retry_cnt),
    .last_fault_id(last_fault_id), .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int pwr, input int cw,
                         input int frn, input int lk, input int rc, input int lf);
    chk({tag, ".state"}, ctrl_state, st);
    chk({tag, ".pwr_en"}, pwr_en, pwr);
    chk({tag, ".clear_warning"}, clear_warning, cw);
    chk({tag, ".fsm_rst_n"}, fsm_rst_n, frn);
    chk({tag, ".lockout"}, lockout, lk);
    chk({tag, ".retry_cnt"}, retry_cnt, rc);
    chk({tag, ".last_fault_id"}, last_fault_id, lf);
  endtask

  task automatic set_in(input bit s, input bit p, input bit lc, input bit w,
                        input bit sd, input bit rw, input int id);
    start = s; stop = p; lockout_clear = lc; warn = w; shutdown = sd;
    raw_fault_any = rw; active_fault_id = 3'(id);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Assert reset between edges and expect every output back at its reset value at once.
  task automatic reset_mid(input string tag);
    #2 rst_n = 1'b0;
    #1 chk_all(tag, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int n;
    bit start, stop, lclr, warn, sd, raw;
    int afid;
    int st; bit pwr, cw, frn, lk; int rc, lf;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(int n, bit s, bit p, bit lc, bit w, bit sd, bit rw, int id,
                              int st, bit pwr, bit cw, bit frn, bit lk, int rc, int lf);
    vec_t v;
    v.n = n; v.start = s; v.stop = p; v.lclr = lc; v.warn = w; v.sd = sd; v.raw = rw;
    v.afid = id; v.st = st; v.pwr = pwr; v.cw = cw; v.frn = frn; v.lk = lk; v.rc = rc; v.lf = lf;
    tbl.push_back(v);
  endfunction

  // ---------------- reference model ----------------
  // Each wait is a "cycles still owed" countdown, reloaded on disturbance.
  int m_mode, m_rc, m_lf, stable_left, cool_left, rearm_left, healthy_left;
  bit m_pwr, m_cw, m_frn, m_lk, m_to_off;

  task automatic m_reset();
    m_mode = 0; m_rc = 0; m_lf = 0; m_pwr = 0; m_cw = 0; m_frn = 1; m_lk = 0; m_to_off = 0;
    stable_left = STAB; cool_left = COOL; rearm_left = REARM; healthy_left = HLTH;
  endtask

  task automatic m_enter_run();
    m_mode = 1; m_pwr = 1; stable_left = STAB; healthy_left = HLTH;
  endtask

  task automatic m_step(input bit s, input bit p, input bit lc, input bit w,
                        input bit sd, input bit rw, input int id);
    m_cw = 0;
    case (m_mode)
      0: if (s && !p && !rw && !sd) m_enter_run();
      1: begin
        if (sd) begin
          m_mode = 2; m_pwr = 0; m_lf = id; if (m_rc < 7) m_rc++;
        end else if (p) begin
          m_mode = 0; m_pwr = 0;
        end else begin
          if (w && !rw) begin
            stable_left--;
            if (stable_left == 0) begin m_cw = 1; stable_left = STAB; end
          end else stable_left = STAB;
          if (w) healthy_left = HLTH;
          else if (healthy_left > 0) begin
            healthy_left--;
            if (healthy_left == 0) m_rc = 0;
          end
        end
      end
      2: if (m_rc >= MAXR) begin m_mode = 5; m_lk = 1; end
         else begin m_mode = 3; cool_left = COOL; end
      3: begin
        if (p) begin m_mode = 0; m_to_off = 0; end
        else if (rw) cool_left = COOL;
        else begin
          cool_left--;
          if (cool_left == 0) begin m_mode = 4; m_frn = 0; rearm_left = REARM; end
        end
      end
      4: begin
        if (p) begin m_mode = 0; m_frn = 1; m_to_off = 0; end
        else if (rw) begin m_mode = 3; m_frn = 1; cool_left = COOL; end
        else begin
          rearm_left--;
          if (rearm_left == 0) begin
            m_frn = 1;
            if (m_to_off) m_mode = 0; else m_enter_run();
            m_to_off = 0;
          end
        end
      end
      5: if (lc && !rw) begin
           m_mode = 4; m_lk = 0; m_rc = 0; m_frn = 0; rearm_left = REARM; m_to_off = 1;
         end
      default: m_mode = 0;
    endcase
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_all("reset", 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;

    //    n  st sp lc wn sd rw id | st pw cw fr lk rc lf
    add(  1, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 1, 0, 0, 0); // start
    add(  1, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0); // stop
    add(  1, 1, 0, 0, 0, 0, 1, 0,   0, 0, 0, 1, 0, 0, 0); // start blocked by raw fault
    add(  1, 1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0); // start+stop stays off
    add(  1, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 1, 0, 0, 0);
    add(  3, 0, 0, 0, 1, 0, 0, 0,   1, 1, 0, 1, 0, 0, 0); // stable warn, counting
    add(  1, 0, 0, 0, 1, 0, 0, 0,   1, 1, 1, 1, 0, 0, 0); // 4th cycle -> pulse
    add(  1, 0, 0, 0, 1, 0, 1, 0,   1, 1, 0, 1, 0, 0, 0); // pulse is one cycle
    add(  3, 0, 0, 0, 1, 0, 0, 0,   1, 1, 0, 1, 0, 0, 0); // raw toggling every 3
    add(  3, 0, 0, 0, 1, 0, 1, 0,   1, 1, 0, 1, 0, 0, 0);
    add(  3, 0, 0, 0, 1, 0, 0, 0,   1, 1, 0, 1, 0, 0, 0);
    add(  3, 0, 0, 0, 1, 0, 1, 0,   1, 1, 0, 1, 0, 0, 0);
    add(  1, 0, 0, 0, 0, 1, 0, 3,   2, 0, 0, 1, 0, 1, 3); // trip id 3
    add(  5, 0, 0, 0, 0, 0, 1, 0,   3, 0, 0, 1, 0, 1, 3); // raw held: cooldown
    add(  9, 0, 0, 0, 0, 0, 0, 0,   3, 0, 0, 1, 0, 1, 3);
    add(  1, 0, 0, 0, 0, 0, 0, 0,   4, 0, 0, 0, 0, 1, 3); // 10th clear -> rearm
    add(  1, 0, 0, 0, 0, 0, 0, 0,   4, 0, 0, 0, 0, 1, 3);
    add(  1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 1, 0, 1, 3); // back to run
    add(  1, 0, 0, 0, 0, 1, 0, 5,   2, 0, 0, 1, 0, 2, 5); // second trip
    add(  1, 0, 0, 0, 0, 0, 0, 0,   5, 0, 0, 1, 1, 2, 5); // lockout
    add(  1, 1, 0, 0, 0, 0, 0, 0,   5, 0, 0, 1, 1, 2, 5); // start ignored
    add(  1, 0, 1, 0, 0, 0, 0, 0,   5, 0, 0, 1, 1, 2, 5); // stop ignored
    add(  1, 0, 0, 1, 0, 0, 1, 0,   5, 0, 0, 1, 1, 2, 5); // clear with raw ignored
    add(  1, 0, 0, 1, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0, 5); // clear accepted
    add(  1, 0, 0, 0, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0, 5);
    add(  1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 5); // rearm exits to OFF
    add(  1, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 1, 0, 0, 5);
    add(  1, 0, 0, 0, 0, 1, 0, 2,   2, 0, 0, 1, 0, 1, 2);
    add(  1, 0, 0, 0, 0, 0, 0, 0,   3, 0, 0, 1, 0, 1, 2);
    add(  9, 0, 0, 0, 0, 0, 0, 0,   3, 0, 0, 1, 0, 1, 2);
    add(  2, 0, 0, 0, 0, 0, 0, 0,   4, 0, 0, 0, 0, 1, 2);
    add(  1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 1, 0, 1, 2);
    add( 49, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 1, 0, 1, 2); // healthy run
    add(  1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 1, 0, 0, 2); // 50th -> forgiven
    add(  1, 0, 1, 0, 0, 1, 0, 6,   2, 0, 0, 1, 0, 1, 6); // shutdown beats stop
    add(  1, 0, 0, 0, 0, 0, 0, 0,   3, 0, 0, 1, 0, 1, 6);
    add(  1, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 1, 6); // stop in cooldown keeps count

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].n; r++) begin
        set_in(tbl[i].start, tbl[i].stop, tbl[i].lclr, tbl[i].warn, tbl[i].sd, tbl[i].raw, tbl[i].afid);
        step();
        chk_all($sformatf("vec%0d.%0d", i, r), tbl[i].st, tbl[i].pwr, tbl[i].cw,
                tbl[i].frn, tbl[i].lk, tbl[i].rc, tbl[i].lf);
      end
    end

    // Reset from OFF also drops the retained retry count.
    set_in(0, 0, 0, 0, 0, 0, 0);
    reset_mid("rst_off");

    // Reset mid-COOLDOWN
    set_in(1, 0, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 1, 0, 4); step();
    set_in(0, 0, 0, 0, 0, 0, 0); repeat (3) step();
    chk("pre_rst_cool.state", ctrl_state, 3);
    reset_mid("rst_cool");

    // Reset mid-REARM (fsm_rst_n low at that moment)
    set_in(1, 0, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 1, 0, 4); step();
    set_in(0, 0, 0, 0, 0, 0, 0); repeat (COOL + 1) step();
    chk("pre_rst_rearm.state", ctrl_state, 4);
    chk("pre_rst_rearm.fsm_rst_n", fsm_rst_n, 0);
    reset_mid("rst_rearm");

    // Random stimulus against the model
    m_reset();
    for (int c = 0; c < 4000; c++) begin
      bit s, p, lc, sd, rw;
      int id;
      s  = ($urandom_range(1, 0) == 1);
      p  = ($urandom_range(19, 0) == 0);
      lc = ($urandom_range(7, 0) == 0);
      sd = ($urandom_range(29, 0) == 0);
      rw = ($urandom_range(9, 0) == 0);
      id = $urandom_range(7, 0);
      if ($urandom_range(9, 0) == 0) warn = ~warn;
      fsm_state = 2'($urandom_range(3, 0));
      set_in(s, p, lc, warn, sd, rw, id);
      m_step(s, p, lc, warn, sd, rw, id);
      step();
      chk_all("rnd", m_mode, m_pwr, m_cw, m_frn, m_lk, m_rc, m_lf);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
